// File: rtl/axi_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect master and a register-bank slave.
// Clock and reset stay outside the bundle as plain ports.
interface axi_lite_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // write address
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  // write data
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  // write response
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  // read address
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  // read data
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite leaf slave over a byte-addressable register file.
// AW and W are captured independently into holding registers and commit
// together; B and R are single-entry registered responses with backpressure.
// Storage is split into one byte-lane slice per strobe bit, so a strobed
// write only touches the enabled lanes of the addressed register.
// DATA_WIDTH must be 32 or 64; NUM_REGS a power of two >= 2; BASE_ADDR
// aligned to the bank size.

// One byte lane of the register bank: NUM_REGS bytes, one write port,
// one asynchronous read port (returns the value before any same-edge write).
module axi_lite_slave_regfile_lane #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wbyte,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rbyte
);
  logic [NUM_REGS-1:0][7:0] mem;

  // byte storage; cleared by reset, written only on a strobed in-range commit
  always_ff @(posedge ACLK) begin
    if (!ARESETn) mem <= '0;
    else if (we)  mem[widx] <= wbyte;
  end

  assign rbyte = mem[ridx];
endmodule

module axi_lite_slave_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic ACLK,
  input logic ARESETn,
  axi_lite_slave_regfile_if.slave s
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int LANE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
  } wr_req_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    dec_t d;
    off   = a - BASE_ADDR;
    d.hit = (off < SPAN);
    d.idx = off[LANE_LSB +: IDX_W];
    return d;
  endfunction

  // ---------------- state ----------------
  logic                      rdy_en;     // readies held low until one edge after reset release
  logic                      aw_held;
  logic                      w_held;
  wr_req_t                   wq;         // latched AW / W fields
  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  logic                      rvalid_q;
  logic [1:0]                rresp_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

  // ---------------- handshakes ----------------
  logic    aw_hs, w_hs, ar_hs, commit;
  wr_req_t wc;                           // write request as seen at the commit edge
  dec_t    wdec, rdec;
  logic [STRB_W-1:0][7:0] rd_lane;

  // Readies come from registered state only; no VALID feeds back into them.
  assign s.AWREADY = rdy_en & ~aw_held & ~bvalid_q;
  assign s.WREADY  = rdy_en & ~w_held  & ~bvalid_q;
  assign s.ARREADY = rdy_en & ~rvalid_q;

  assign aw_hs  = s.AWVALID & s.AWREADY;
  assign w_hs   = s.WVALID  & s.WREADY;
  assign ar_hs  = s.ARVALID & s.ARREADY;
  // commit once both halves are available, held or arriving this cycle
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);

  assign s.BVALID = bvalid_q;
  assign s.BRESP  = bresp_q;
  assign s.RVALID = rvalid_q;
  assign s.RRESP  = rresp_q;
  assign s.RDATA  = rdata_q;

  // merge held and live channel fields into the request that commits
  always_comb begin
    wc      = '0;
    wc.addr = aw_held ? wq.addr : s.AWADDR;
    wc.data = w_held  ? wq.data : s.WDATA;
    wc.strb = w_held  ? wq.strb : s.WSTRB;
  end

  assign wdec = decode(wc.addr);
  assign rdec = decode(s.ARADDR);

  // ---------------- storage: one slice per byte lane ----------------
  for (genvar g = 0; g < STRB_W; g++) begin : g_lane
    axi_lite_slave_regfile_lane #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
    ) u_lane (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .we      (commit & wdec.hit & wc.strb[g]),
      .widx    (wdec.idx),
      .wbyte   (wc.data[8*g +: 8]),
      .ridx    (rdec.idx),
      .rbyte   (rd_lane[g])
    );
  end

  // ready enable: low in reset, rises on the first edge after release
  always_ff @(posedge ACLK) begin
    if (!ARESETn) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // write path: hold AW / W independently, commit together, then respond on B
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wq       <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      // readies are low while BVALID is up, so commit never overlaps a pending B
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= wdec.hit ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        wq.addr <= s.AWADDR;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wq.data <= s.WDATA;
        wq.strb <= s.WSTRB;
      end
      if (bvalid_q && s.BREADY) bvalid_q <= 1'b0;
    end
  end

  // read path: register data/response at the AR handshake, hold until accepted
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rdec.hit ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= rdec.hit ? DATA_WIDTH'(rd_lane) : '0;
    end else if (rvalid_q && s.RREADY) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule

// File: doc/axi_lite_slave_regfile.md
# axi_lite_slave_regfile

Parametrised AXI4-Lite slave: an independent five-channel handshake front end over a byte-addressable register file. It replaces the fixed single-register slave with configurable data width, register count and base address. It adds byte strobes, out-of-range decode with SLVERR, and full backpressure on B and R. It sits behind the interconnect as a leaf slave, one instance per peripheral register bank.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data width; 32 or 64 only
- NUM_REGS, 8, number of DATA_WIDTH registers; power of two, at least 2
- BASE_ADDR, 0, byte address of register 0; aligned to NUM_REGS*DATA_WIDTH/8
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- AWADDR  in  ADDR_WIDTH  write address
- AWVALID / AWREADY  in / out  1  write-address handshake
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte enables
- WVALID / WREADY  in / out  1  write-data handshake
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- BVALID / BREADY  out / in  1  write-response handshake
- ARADDR  in  ADDR_WIDTH  read address
- ARVALID / ARREADY  in / out  1  read-address handshake
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response, same encoding as BRESP
- RVALID / RREADY  out / in  1  read-data handshake

## Operation
- Decode: offset = addr - BASE_ADDR. In range when offset < NUM_REGS*DATA_WIDTH/8. Index = offset >> log2(DATA_WIDTH/8). Low byte-lane bits are ignored.
- Write path: holding flags aw_held and w_held, with latched address, data and strobe.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - AW and W are accepted in any order or in the same cycle.
  - Commit occurs at the edge where both are available, either held or being handshaken that cycle.
- Commit:
  - In range: each byte lane with WSTRB=1 is written and the other lanes are kept. BRESP=OKAY.
  - Out of range: no register changes. BRESP=SLVERR.
  - WSTRB all zero in range: no change, OKAY.
  - At commit, BVALID goes to 1 and both held flags clear.
- Response: BVALID and BRESP are stable until BVALID&&BREADY, then BVALID=0.
- Read path: ARREADY = !RVALID.
  - On ARVALID&&ARREADY, RDATA and RRESP are registered and RVALID goes to 1.
  - In range: RDATA = reg[index], OKAY. Out of range: RDATA = 0, SLVERR.
  - RDATA, RRESP and RVALID are stable until RVALID&&RREADY.
- Read and write channels are fully independent and may complete in the same cycle.
- Same-cycle read and commit to the same register: the read returns the pre-write value.

## Timing
- Reset, at the edge with ARESETn=0:
  - All registers, BVALID, RVALID, RDATA and the held flags go to 0. BRESP=RRESP=2'b00.
  - While in reset, AWREADY, WREADY and ARREADY are 0.
  - Ready outputs rise one cycle after ARESETn returns to 1.
- Write latency: BVALID rises at the edge that completes the later of the AW and W handshakes.
- Earliest next write handshake: the cycle after BVALID&&BREADY.
- Read latency: RVALID rises at the edge of the AR handshake.
- Throughput: one read every 2 cycles with RREADY held at 1. Same for writes with BREADY held at 1.
- Reset mid-transaction: pending AW/W, B or R is discarded with no register update, and no response is issued after reset.
- Ready outputs are combinational from registered state only, with no path from VALID inputs.

## Test plan
- Full write/read: AWADDR=0x4, WDATA=0xDEADBEEF, WSTRB=4'hF, same cycle -> BVALID next edge with OKAY. Read 0x4 -> RDATA=0xDEADBEEF, OKAY.
- Partial strobe: reg1=0xDEADBEEF. Write 0x4 with WDATA=0x11223344, WSTRB=4'b0101 -> read gives 0xDE22BE44.
- Skewed channels: AW at cycle 0, W at cycle 3 -> AWREADY=0 during cycles 1-3, BVALID rises at the cycle-3 edge. Repeat with W before AW.
- Out of range: with BASE_ADDR=0 and NUM_REGS=8, write 0x20 -> SLVERR and all regs unchanged. Read 0x20 -> RDATA=0, SLVERR.
- Backpressure: RREADY=0 for 5 cycles -> RVALID, RDATA and RRESP stable and ARREADY=0 throughout. Same with BREADY=0 for the B channel.
- Reset mid-operation: AW accepted, W pending, ARESETn=0 for one cycle -> BVALID stays 0 and registers read back 0.
